// File: rtl/rf_dump_pkg.sv
// rtl/rf_dump_pkg.sv - shared constants and FSM state type for the register-file dump reader
package rf_dump_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rf_dump_if.sv
// rtl/rf_dump_if.sv - control, RF read port and output stream bundle for rf_dump
// Optional macro RF_DUMP_FREEZE_EN adds core_stall.
// master: the dump engine (drives busy/done/rf_addr/out_*), slave: core + sink side.
interface rf_dump_if #(
    parameter int ADDR_W = rf_dump_pkg::ADDR_W,
    parameter int DATA_W = rf_dump_pkg::DATA_W
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              out_last;
`ifdef RF_DUMP_FREEZE_EN
    logic              core_stall;
`endif

    modport master (
        input  start, rf_data, out_ready,
        output busy, done, rf_addr, out_valid, out_data, out_idx, out_last
`ifdef RF_DUMP_FREEZE_EN
        , output core_stall
`endif
    );

    modport slave (
        output start, rf_data, out_ready,
        input  busy, done, rf_addr, out_valid, out_data, out_idx, out_last
`ifdef RF_DUMP_FREEZE_EN
        , input core_stall
`endif
    );

endinterface

// File: rtl/rf_dump.sv
// rtl/rf_dump.sv - walks RF addresses 0..NUM_REGS-1 on start and streams each value out
// Ports: clk, rst (sync, active-high), bus (rf_dump_if.master: start/busy/done,
// rf_addr/rf_data read port, out_valid/out_ready/out_data/out_idx/out_last stream,
// core_stall when RF_DUMP_FREEZE_EN is defined).
module rf_dump
    import rf_dump_pkg::*;
#(
    parameter int NUM_REGS = rf_dump_pkg::NUM_REGS,
    parameter int ADDR_W   = rf_dump_pkg::ADDR_W,
    parameter int DATA_W   = rf_dump_pkg::DATA_W
) (
    input  logic        clk,
    input  logic        rst,
    rf_dump_if.master   bus
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_out_idx;
    logic              r_out_last;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_done;

    logic              w_handshake;

    assign w_handshake = r_out_valid && bus.out_ready;

    // The counter doubles as the RF address; outside READ it simply holds.
    assign bus.rf_addr   = r_cnt;
    assign bus.out_data  = r_out_data;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_last  = r_out_last;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

`ifdef RF_DUMP_FREEZE_EN
    // Freezing the core for the whole dump makes the captured words one snapshot.
    assign bus.core_stall = r_busy;
`else
    // Without freeze the core keeps writing; each word is sampled when it is read.
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= READ;
                    end
                end
                READ: begin
                    // Single sample point per word; later RF writes do not touch it.
                    r_out_data  <= bus.rf_data;
                    r_out_idx   <= r_cnt;
                    r_out_last  <= (r_cnt == LAST_IDX);
                    r_out_valid <= 1'b1;
                    r_state     <= SEND;
                end
                SEND: begin
                    if (w_handshake) begin
                        r_out_valid <= 1'b0;
                        if (r_out_last) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= READ;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
